// File: rtl/kyber_io_pkg.sv
// rtl/kyber_io_pkg.sv - shared constants, encodings and FSM state for the Kyber host bridge
package kyber_io_pkg;

    localparam int DW     = 32;
    localparam int COIN_W = 8;
    localparam int M_W    = 8;
    localparam int PK_W   = 200;
    localparam int SK_W   = 192;
    localparam int C_W    = 192;

    localparam logic [2:0] SEL_COIN = 3'd0;
    localparam logic [2:0] SEL_M    = 3'd1;
    localparam logic [2:0] SEL_PK   = 3'd2;
    localparam logic [2:0] SEL_SK   = 3'd3;
    localparam logic [2:0] SEL_C    = 3'd4;

    localparam logic [1:0] MODE_KEYGEN  = 2'd0;
    localparam logic [1:0] MODE_ENCRYPT = 2'd1;
    localparam logic [1:0] MODE_DECRYPT = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Word capacity of a write target; invalid selects report zero so every word to them is rejected
    function automatic logic [15:0] sel_words(input logic [2:0] sel);
        case (sel)
            SEL_COIN: return 16'(COIN_W);
            SEL_M:    return 16'(M_W);
            SEL_PK:   return 16'(PK_W);
            SEL_SK:   return 16'(SK_W);
            SEL_C:    return 16'(C_W);
            default:  return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/kyber_word_slicer.sv
// rtl/kyber_word_slicer.sv - combinational extractor of one DW-bit word from a wide bus
module kyber_word_slicer #(
    parameter int DW    = 32,
    parameter int WORDS = 200,
    parameter int IW    = 8
) (
    input  logic [DW*WORDS-1:0] bus,
    input  logic [IW-1:0]       idx,
    output logic [DW-1:0]       word
);

    localparam int OW = $clog2(DW * WORDS);

    logic [OW-1:0] off;

    // Word idx lives at bits [DW*idx +: DW]; out-of-range indices read as zero
    always_comb begin
        word = '0;
        off  = OW'(int'(idx) * DW);
        if (int'(idx) < WORDS) begin
            word = bus[off +: DW];
        end
    end

endmodule

// File: rtl/kyber_host_if.sv
// rtl/kyber_host_if.sv - word-serial host bridge that loads, launches and drains the Kyber core
module kyber_host_if
    import kyber_io_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_sel,
    input  logic [DW-1:0]      wr_data,
    input  logic               wr_last,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [DW-1:0]      rd_data,
    output logic               rd_last,
    output logic               busy,
    output logic               err,
    output logic               core_start,
    output logic [1:0]         core_mode,
    output logic [DW*COIN_W-1:0] random_coin,
    output logic [DW*M_W-1:0]  m_in,
    output logic [DW*PK_W-1:0] pk_in,
    output logic [DW*SK_W-1:0] sk_in,
    output logic [DW*C_W-1:0]  c_in,
    input  logic               core_finish,
    input  logic [DW*M_W-1:0]  m_out,
    input  logic [DW*PK_W-1:0] pk_out,
    input  logic [DW*SK_W-1:0] sk_out,
    input  logic [DW*C_W-1:0]  c_out
);

    state_t state, state_next;

    logic [15:0]        p;
    logic [7:0]         q;
    logic               seg;
    logic [7:0]         off_s;
    logic [12:0]        off_b;
    logic [DW*PK_W-1:0] seg_bus;
    logic [7:0]         seg_len;
    logic               last_seg;
    logic [DW-1:0]      seg_word;
    logic               wr_fire;
    logic               cmd_fire;
    logic               rd_fire;

    assign off_s    = {p[2:0], 5'b0};
    assign off_b    = {p[7:0], 5'b0};
    assign wr_fire  = wr_valid && wr_ready;
    assign cmd_fire = cmd_valid && cmd_ready;
    assign rd_fire  = rd_valid && rd_ready;

    // Select the result segment being drained: keygen walks pk then sk, other modes have one segment
    always_comb begin
        seg_bus  = pk_out;
        seg_len  = 8'(PK_W);
        last_seg = 1'b0;
        case (core_mode)
            MODE_KEYGEN: begin
                if (seg) begin
                    seg_bus  = {{(DW*(PK_W-SK_W)){1'b0}}, sk_out};
                    seg_len  = 8'(SK_W);
                    last_seg = 1'b1;
                end
            end
            MODE_ENCRYPT: begin
                seg_bus  = {{(DW*(PK_W-C_W)){1'b0}}, c_out};
                seg_len  = 8'(C_W);
                last_seg = 1'b1;
            end
            default: begin
                seg_bus  = {{(DW*(PK_W-M_W)){1'b0}}, m_out};
                seg_len  = 8'(M_W);
                last_seg = 1'b1;
            end
        endcase
    end

    kyber_word_slicer #(
        .DW   (DW),
        .WORDS(PK_W),
        .IW   (8)
    ) u_slicer (
        .bus (seg_bus),
        .idx (q),
        .word(seg_word)
    );

    assign rd_last = (state == ST_DRAIN) && last_seg && (q == seg_len - 8'd1);
    assign rd_data = (state == ST_DRAIN) ? seg_word : '0;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; host ports open only in IDLE
    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        cmd_ready  = 1'b0;
        core_start = 1'b0;
        rd_valid   = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                wr_ready  = 1'b1;
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_mode != MODE_RSVD)) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                core_start = 1'b1;
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (core_finish) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                rd_valid = 1'b1;
                if (rd_ready && rd_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: buffer loads, shared write pointer, sticky error, mode latch and drain indices
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            random_coin <= '0;
            m_in        <= '0;
            pk_in       <= '0;
            sk_in       <= '0;
            c_in        <= '0;
            p           <= '0;
            q           <= '0;
            seg         <= 1'b0;
            err         <= 1'b0;
            core_mode   <= 2'd0;
        end else begin
            if (wr_fire) begin
                p <= wr_last ? 16'd0 : p + 16'd1;
                if (p >= sel_words(wr_sel)) begin
                    err <= 1'b1;
                end else begin
                    case (wr_sel)
                        SEL_COIN: random_coin[off_s +: DW] <= wr_data;
                        SEL_M:    m_in[off_s +: DW]        <= wr_data;
                        SEL_PK:   pk_in[off_b +: DW]       <= wr_data;
                        SEL_SK:   sk_in[off_b +: DW]       <= wr_data;
                        SEL_C:    c_in[off_b +: DW]        <= wr_data;
                        default: ;
                    endcase
                end
            end
            if (cmd_fire) begin
                if (cmd_mode == MODE_RSVD) begin
                    err <= 1'b1;
                end else begin
                    core_mode <= cmd_mode;
                end
            end
            if ((state == ST_BUSY) && core_finish) begin
                q   <= '0;
                seg <= 1'b0;
            end else if (rd_fire) begin
                if (q == seg_len - 8'd1) begin
                    q   <= '0;
                    seg <= 1'b1;
                end else begin
                    q <= q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kyber_host_if.sv
// tb/tb_kyber_host_if.sv - self-checking bench for kyber_host_if
module tb_kyber_host_if;
    import kyber_io_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_valid;
    logic               wr_ready;
    logic [2:0]         wr_sel;
    logic [31:0]        wr_data;
    logic               wr_last;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_mode;
    logic               rd_valid;
    logic               rd_ready;
    logic [31:0]        rd_data;
    logic               rd_last;
    logic               busy;
    logic               err;
    logic               core_start;
    logic [1:0]         core_mode;
    logic [255:0]       random_coin;
    logic [255:0]       m_in;
    logic [6399:0]      pk_in;
    logic [6143:0]      sk_in;
    logic [6143:0]      c_in;
    logic               core_finish;
    logic [255:0]       m_out;
    logic [6399:0]      pk_out;
    logic [6143:0]      sk_out;
    logic [6143:0]      c_out;

    int n_tests   = 0;
    int n_fail    = 0;
    int start_cnt = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] data;
        logic        last;
        logic        exp_err;
    } wr_vec_t;

    wr_vec_t wv [17];

    always #5 clk = ~clk;

    kyber_host_if dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .busy       (busy),
        .err        (err),
        .core_start (core_start),
        .core_mode  (core_mode),
        .random_coin(random_coin),
        .m_in       (m_in),
        .pk_in      (pk_in),
        .sk_in      (sk_in),
        .c_in       (c_in),
        .core_finish(core_finish),
        .m_out      (m_out),
        .pk_out     (pk_out),
        .sk_out     (sk_out),
        .c_out      (c_out)
    );

    // Core model: counts launches and raises finish for one cycle 50 cycles after each start
    initial begin
        core_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                start_cnt++;
                repeat (50) @(posedge clk);
                #1 core_finish = 1'b1;
                @(posedge clk);
                #1 core_finish = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [1:0] mode, input int k);
        case (mode)
            2'd0:    return (k < 200) ? 32'h1000_0000 + 32'(k) : 32'h2000_0000 + 32'(k - 200);
            2'd1:    return 32'h3000_0000 + 32'(k);
            default: return 32'h4000_0000 + 32'(k);
        endcase
    endfunction

    // All tasks start and end at 1 time unit after a rising edge
    task automatic do_write(input logic [2:0] sel, input logic [31:0] data, input logic last);
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_data  = data;
        wr_last  = last;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic apply_writes(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            do_write(wv[i].sel, wv[i].data, wv[i].last);
            check($sformatf("wr_err[%0d]", i), {31'b0, err}, {31'b0, wv[i].exp_err});
        end
    endtask

    task automatic do_cmd(input logic [1:0] mode);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int n, input logic [1:0] mode, input bit toggle, input int stop);
        int k = 0;
        int cyc = 0;
        while (!rd_valid && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_valid", {31'b0, rd_valid}, 32'd1);
        cyc = 0;
        while (k < stop && cyc < 2000) begin
            rd_ready = toggle ? !cyc[0] : 1'b1;
            #3;
            if (rd_valid) begin
                check($sformatf("rd_data[%0d]", k), rd_data, exp_word(mode, k));
                check($sformatf("rd_last[%0d]", k), {31'b0, rd_last}, {31'b0, (k == n - 1)});
                if (rd_ready) k++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_count", 32'(k), 32'(stop));
        rd_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_rd_valid"}, {31'b0, rd_valid}, 32'd0);
        check({tag, "_rd_last"}, {31'b0, rd_last}, 32'd0);
        check({tag, "_rd_data"}, rd_data, 32'd0);
        check({tag, "_core_start"}, {31'b0, core_start}, 32'd0);
        check({tag, "_core_mode"}, {30'b0, core_mode}, 32'd0);
        check({tag, "_bufs_zero"}, {31'b0, |{random_coin, m_in, pk_in, sk_in, c_in}}, 32'd0);
    endtask

    initial begin
        int s0;
        rst       = 1'b0;
        wr_valid  = 1'b0;
        wr_sel    = 3'd0;
        wr_data   = 32'd0;
        wr_last   = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        rd_ready  = 1'b0;
        for (int i = 0; i < 200; i++) pk_out[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 192; i++) sk_out[i*32 +: 32] = 32'h2000_0000 + 32'(i);
        for (int i = 0; i < 192; i++) c_out[i*32 +: 32]  = 32'h3000_0000 + 32'(i);
        for (int i = 0; i < 8; i++)   m_out[i*32 +: 32]  = 32'h4000_0000 + 32'(i);
        for (int i = 0; i < 8; i++) wv[i] = '{SEL_COIN, 32'(i + 1), (i == 7), 1'b0};
        for (int j = 0; j < 9; j++) wv[8 + j] = '{SEL_M, 32'hA000_0000 + 32'(j), (j == 8), (j == 8)};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_wr_ready", {31'b0, wr_ready}, 32'd1);
        check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Coin load then keygen
        apply_writes(0, 7);
        check("coin_w0", random_coin[31:0], 32'd1);
        check("coin_w7", random_coin[255:224], 32'd8);
        s0 = start_cnt;
        do_cmd(MODE_KEYGEN);
        check("kg_start", {31'b0, core_start}, 32'd1);
        check("kg_busy", {31'b0, busy}, 32'd1);
        check("kg_wr_ready", {31'b0, wr_ready}, 32'd0);
        drain(392, MODE_KEYGEN, 1'b0, 392);
        check("kg_busy_end", {31'b0, busy}, 32'd0);
        check("kg_starts", 32'(start_cnt - s0), 32'd1);

        // Encrypt with stalling reader
        do_cmd(MODE_ENCRYPT);
        check("enc_mode", {30'b0, core_mode}, 32'd1);
        drain(192, MODE_ENCRYPT, 1'b1, 192);
        check("enc_busy_end", {31'b0, busy}, 32'd0);

        // Write and decrypt command in the same cycle
        wr_valid  = 1'b1;
        wr_sel    = SEL_M;
        wr_data   = 32'hDEAD_BEEF;
        wr_last   = 1'b1;
        cmd_valid = 1'b1;
        cmd_mode  = MODE_DECRYPT;
        @(posedge clk);
        #1;
        wr_valid  = 1'b0;
        wr_last   = 1'b0;
        cmd_valid = 1'b0;
        check("same_start", {31'b0, core_start}, 32'd1);
        check("same_m_w0", m_in[31:0], 32'hDEAD_BEEF);
        drain(8, MODE_DECRYPT, 1'b0, 8);
        check("dec_busy_end", {31'b0, busy}, 32'd0);

        // Overlong m load: ninth word rejected, pointer back to 0
        check("pre_err", {31'b0, err}, 32'd0);
        apply_writes(8, 16);
        for (int i = 0; i < 8; i++) check($sformatf("m_w%0d", i), m_in[i*32 +: 32], 32'hA000_0000 + 32'(i));
        do_write(SEL_COIN, 32'hCAFE_F00D, 1'b1);
        check("p_zero", random_coin[31:0], 32'hCAFE_F00D);

        // Reserved mode after a reset clears err
        rst = 1'b0;
        #1;
        check("rst2_err", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        s0 = start_cnt;
        do_cmd(MODE_RSVD);
        check("rsvd_start", {31'b0, core_start}, 32'd0);
        check("rsvd_busy", {31'b0, busy}, 32'd0);
        check("rsvd_err", {31'b0, err}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rsvd_busy2", {31'b0, busy}, 32'd0);
        check("rsvd_starts", 32'(start_cnt - s0), 32'd0);

        // Reset mid-drain at word 100, then a clean keygen
        do_cmd(MODE_ENCRYPT);
        drain(192, MODE_ENCRYPT, 1'b0, 100);
        check("mid_valid", {31'b0, rd_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        #1;
        rst = 1'b1;
        s0 = start_cnt;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_start", 32'(start_cnt - s0), 32'd0);
        do_cmd(MODE_KEYGEN);
        check("kg2_start", {31'b0, core_start}, 32'd1);
        drain(392, MODE_KEYGEN, 1'b0, 392);
        check("kg2_busy_end", {31'b0, busy}, 32'd0);
        check("kg2_starts", 32'(start_cnt - s0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
